wb_master_port: RTL

Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into one bus cycle and returns the result on a valid/ready response stream. It sits on the management side of the user-project Wishbone interface (WB MI A). It drives slaves such as the user-area counter project, and a bench or sequencer uses it to issue reads and writes. A programmable timeout terminates cycles that never receive `ack`, so an unresponsive slave cannot hang the initiator.

---
 rtl/wb_master_pkg.sv | 9 +
 rtl/wb_timeout_cnt.sv | 18 +
 rtl/wb_master_port.sv | 72 +++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared bus widths and FSM encoding for the Wishbone initiator
package wb_master_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: saturating wait counter that flags an unresponsive slave
module wb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT - 1);
  // count stalled bus cycles and hold at the terminal value instead of wrapping
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni || clear) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone classic initiator with command/response streams
module wb_master_port
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i
);
  logic [1:0] state;
  logic       expired;
  assign cmd_ready = state == ST_IDLE;
  assign rsp_valid = state == ST_RESP;
  assign wbm_cyc_o = state == ST_BUS;
  assign wbm_stb_o = wbm_cyc_o;
  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .clear    (cmd_valid && cmd_ready),
    .en       (wbm_cyc_o && !wbm_ack_i),
    .expired  (expired)
  );
  // accept a command, run one bus cycle until ack or timeout, then hold the response
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (cmd_valid) begin
        state     <= ST_BUS;
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
      end
    end else if (state == ST_BUS) begin
      if (wbm_ack_i || expired) begin
        state     <= ST_RESP;
        rsp_dat   <= wbm_ack_i && !wbm_we_o ? wbm_dat_i : '0;
        rsp_err   <= !wbm_ack_i;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= '0;
        wbm_adr_o <= '0;
        wbm_dat_o <= '0;
      end
    end else if (state == ST_RESP) begin
      if (rsp_ready) state <= ST_IDLE;
    end else state <= ST_IDLE;
endmodule
